// File: rtl/aes_decipher_round_pipe.sv
// AES inverse-cipher round stage: InvShiftRows -> external InvSbox ->
// AddRoundKey -> InvMixColumns (skipped when LAST_ROUND=1).
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake for {in_block, in_key, in_tag}
//   sbox_out/sbox_in      InvShiftRows(S0) out, byte-wise InvSbox back in
//   out_valid/out_ready   downstream handshake for {out_block, out_tag}
// Optional (AES_DEC_PERF_CNT_EN):
//   perf_clr              synchronous clear of both counters
//   perf_blocks           output transfers
//   perf_stalls           cycles with out_valid && !out_ready
// PIPE_STAGES=3 keeps a register (S1) after the S-box; 2 drops it.

module aes_decipher_round_pipe #(
  parameter int LAST_ROUND  = 0,
  parameter int PIPE_STAGES = 3,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef AES_DEC_PERF_CNT_EN
  input  logic             perf_clr,
  output logic [31:0]      perf_blocks,
  output logic [31:0]      perf_stalls,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  input  logic [127:0]     in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic [127:0]     sbox_out,
  input  logic [127:0]     sbox_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic [TAG_W-1:0] out_tag
);

  if (PIPE_STAGES != 2 && PIPE_STAGES != 3) begin : g_bad_stages
    $error("PIPE_STAGES must be 2 or 3");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // multiply by a 4-bit constant (09/0b/0d/0e)
  function automatic logic [7:0] gm(input logic [7:0] b,
                                    input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^
           (m[1] ? x2 : 8'h00) ^ (m[0] ? b : 8'h00);
  endfunction

  function automatic logic [31:0] imix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {
      gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
      gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
      gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
      gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)
    };
  endfunction

  function automatic logic [127:0] imix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = imix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // row r rotated right by r: out[r][c] = in[r][c-r]
  function automatic logic [127:0] isr(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  logic             s0_v_q;
  logic [127:0]     s0_blk_q, s0_key_q;
  logic [TAG_W-1:0] s0_tag_q;
  logic             s2_v_q;
  logic [127:0]     s2_blk_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             s1_ld, s2_ld;
  logic             mid_v;
  logic [127:0]     mid_sb, mid_key, rk, res;
  logic [TAG_W-1:0] mid_tag;

  // a stage loads when empty or when its contents move on
  assign s2_ld    = !s2_v_q || out_ready;
  assign in_ready = !s0_v_q || s1_ld;
  assign sbox_out = isr(s0_blk_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s0_v_q   <= 1'b0;
      s0_blk_q <= '0;
      s0_key_q <= '0;
      s0_tag_q <= '0;
    end else if (in_ready) begin
      s0_v_q <= in_valid;
      if (in_valid) begin
        s0_blk_q <= in_block;
        s0_key_q <= in_key;
        s0_tag_q <= in_tag;
      end
    end
  end

  if (PIPE_STAGES == 3) begin : g_s1
    logic             s1_v_q;
    logic [127:0]     s1_sb_q, s1_key_q;
    logic [TAG_W-1:0] s1_tag_q;

    assign s1_ld = !s1_v_q || s2_ld;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        s1_v_q   <= 1'b0;
        s1_sb_q  <= '0;
        s1_key_q <= '0;
        s1_tag_q <= '0;
      end else if (s1_ld) begin
        s1_v_q <= s0_v_q;
        if (s0_v_q) begin
          s1_sb_q  <= sbox_in;
          s1_key_q <= s0_key_q;
          s1_tag_q <= s0_tag_q;
        end
      end
    end

    assign mid_v   = s1_v_q;
    assign mid_sb  = s1_sb_q;
    assign mid_key = s1_key_q;
    assign mid_tag = s1_tag_q;
  end else begin : g_no_s1
    assign s1_ld   = s2_ld;
    assign mid_v   = s0_v_q;
    assign mid_sb  = sbox_in;
    assign mid_key = s0_key_q;
    assign mid_tag = s0_tag_q;
  end

  assign rk  = mid_sb ^ mid_key;
  assign res = (LAST_ROUND != 0) ? rk : imix(rk);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_v_q   <= 1'b0;
      s2_blk_q <= '0;
      s2_tag_q <= '0;
    end else if (s2_ld) begin
      s2_v_q <= mid_v;
      if (mid_v) begin
        s2_blk_q <= res;
        s2_tag_q <= mid_tag;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign out_block = s2_blk_q;
  assign out_tag   = s2_tag_q;

`ifdef AES_DEC_PERF_CNT_EN
  logic [31:0] pb_q, pb_d, ps_q, ps_d;

  always_comb begin
    pb_d = pb_q;
    ps_d = ps_q;
    if (perf_clr) begin
      pb_d = '0;
      ps_d = '0;
    end else begin
      if (out_valid && out_ready)  pb_d = pb_q + 32'd1;
      if (out_valid && !out_ready) ps_d = ps_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pb_q <= '0;
      ps_q <= '0;
    end else begin
      pb_q <= pb_d;
      ps_q <= ps_d;
    end
  end

  assign perf_blocks = pb_q;
  assign perf_stalls = ps_q;
`endif

endmodule

// File: tb/tb_aes_decipher_round_pipe.sv
// Bench for aes_decipher_round_pipe: three instances (final round,
// middle round, 2-stage middle round) against a queue-based model.

module tb_aes_decipher_round_pipe;

  localparam int NI = 3;

  typedef struct {
    logic [127:0] blk;
    logic [3:0]   tag;
    int           t;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, in_valid, out_ready;
  logic         p2_en, sb_ones, run, rec, perf_clr;
  logic [127:0] in_block, in_key;
  logic [3:0]   in_tag;
  logic         all_ready;
  logic         iv [NI];
  logic         ir [NI];
  logic         ov [NI];
  logic [127:0] sbo [NI];
  logic [127:0] sbi [NI];
  logic [127:0] ob [NI];
  logic [3:0]   ot [NI];
  logic [31:0]  pb [NI];
  logic [31:0]  pst [NI];
  logic [7:0]   inv_sb [256];

  ent_t       q [NI][$];
  logic [3:0] tags [$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic int ps_of(input int i);
    return (i == 2) ? 2 : 3;
  endfunction

  function automatic bit last_of(input int i);
    return (i == 0);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] fsbox(input logic [7:0] x);
    logic [7:0] v;
    v = 0;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^
           {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] isub(input logic [127:0] v,
                                        input logic ones);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      r[127-8*k -: 8] = ones ? 8'h01 : inv_sb[v[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] b, k,
                                             input bit last,
                                             input logic ones);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] m [4];
    logic [7:0] acc;
    logic [127:0] o;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = b[127-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        t[r][c] = s[r][(c - r + 4) % 4];
        t[r][c] = ones ? 8'h01 : inv_sb[t[r][c]];
        t[r][c] ^= k[127-8*(4*c+r) -: 8];
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        acc = 0;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(m[(j - r + 4) % 4], t[j][c]);
        s[r][c] = last ? t[r][c] : acc;
      end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  task automatic cmp(input string nm, input logic [127:0] a, e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  assign all_ready = ir[0] && ir[1] && (!p2_en || ir[2]);
  assign iv[0] = in_valid && all_ready;
  assign iv[1] = in_valid && all_ready;
  assign iv[2] = in_valid && p2_en && all_ready;
  assign sbi[0] = isub(sbo[0], sb_ones);
  assign sbi[1] = isub(sbo[1], sb_ones);
  assign sbi[2] = isub(sbo[2], sb_ones);

  aes_decipher_round_pipe #(.LAST_ROUND(1), .PIPE_STAGES(3), .TAG_W(4)) u0 (
    .clk(clk), .reset_n(reset_n),
`ifdef AES_DEC_PERF_CNT_EN
    .perf_clr(perf_clr), .perf_blocks(pb[0]), .perf_stalls(pst[0]),
`endif
    .in_valid(iv[0]), .in_ready(ir[0]), .in_block(in_block),
    .in_key(in_key), .in_tag(in_tag), .sbox_out(sbo[0]),
    .sbox_in(sbi[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_block(ob[0]), .out_tag(ot[0]));

  aes_decipher_round_pipe #(.LAST_ROUND(0), .PIPE_STAGES(3), .TAG_W(4)) u1 (
    .clk(clk), .reset_n(reset_n),
`ifdef AES_DEC_PERF_CNT_EN
    .perf_clr(perf_clr), .perf_blocks(pb[1]), .perf_stalls(pst[1]),
`endif
    .in_valid(iv[1]), .in_ready(ir[1]), .in_block(in_block),
    .in_key(in_key), .in_tag(in_tag), .sbox_out(sbo[1]),
    .sbox_in(sbi[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_block(ob[1]), .out_tag(ot[1]));

  aes_decipher_round_pipe #(.LAST_ROUND(0), .PIPE_STAGES(2), .TAG_W(4)) u2 (
    .clk(clk), .reset_n(reset_n),
`ifdef AES_DEC_PERF_CNT_EN
    .perf_clr(perf_clr), .perf_blocks(pb[2]), .perf_stalls(pst[2]),
`endif
    .in_valid(iv[2]), .in_ready(ir[2]), .in_block(in_block),
    .in_key(in_key), .in_tag(in_tag), .sbox_out(sbo[2]),
    .sbox_in(sbi[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_block(ob[2]), .out_tag(ot[2]));

  // scoreboard: head of a queue is valid once PIPE_STAGES cycles old;
  // a stage set is full exactly when it holds PIPE_STAGES blocks
  always @(negedge clk) begin
    logic ev, er;
    cyc++;
    if (run) begin
      for (int i = 0; i < NI; i++) begin
        ev = 1'b0;
        if (q[i].size() > 0) ev = (cyc - q[i][0].t) >= ps_of(i);
        er = (q[i].size() < ps_of(i)) || out_ready;
        cmp($sformatf("u%0d out_valid", i), 128'(ov[i]), 128'(ev));
        cmp($sformatf("u%0d in_ready", i), 128'(ir[i]), 128'(er));
        if (ev) begin
          cmp($sformatf("u%0d out_block", i), ob[i], q[i][0].blk);
          cmp($sformatf("u%0d out_tag", i), 128'(ot[i]),
              128'(q[i][0].tag));
        end
        if (!reset_n) q[i].delete();
        else begin
          if (iv[i] && er)
            q[i].push_back('{ref_round(in_block, in_key, last_of(i),
                                       sb_ones), in_tag, cyc});
          if (ev && out_ready) begin
            if (rec && i == 1) tags.push_back(ot[1]);
            void'(q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [127:0] b, k, input logic [3:0] t);
    int g;
    in_valid = 1'b1;
    in_block = b;
    in_key   = k;
    in_tag   = t;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!all_ready && g < 50);
    if (!all_ready) cmp("send timeout", 128'(all_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
  endtask

  localparam logic [127:0] CT  = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2  = 128'h00102030405060708090a0b0c0d0e0f0;

  initial begin
    int g;
    reset_n = 0; in_valid = 0; out_ready = 1; p2_en = 1; sb_ones = 0;
    run = 0; rec = 0; perf_clr = 0;
    in_block = '0; in_key = '0; in_tag = '0;
    for (int x = 0; x < 256; x++) inv_sb[fsbox(8'(x))] = 8'(x);

    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      cmp($sformatf("rst u%0d out_valid", i), 128'(ov[i]), 128'(0));
      cmp($sformatf("rst u%0d in_ready", i), 128'(ir[i]), 128'(1));
      cmp($sformatf("rst u%0d out_block", i), ob[i], '0);
      cmp($sformatf("rst u%0d out_tag", i), 128'(ot[i]), 128'(0));
      cmp($sformatf("rst u%0d sbox_out", i), sbo[i], '0);
    end
    run = 1;
    @(posedge clk);
    #1;

    // final round, FIPS-197 appendix C last step
    send(CT, K1, 4'd5);
    @(negedge clk);
    cmp("t1 sbox_out", sbo[0], 128'h63cab7040953d051cd60e0e7ba70e18c);
    repeat (2) @(negedge clk);
    cmp("t1 out_valid", 128'(ov[0]), 128'(1));
    cmp("t1 out_block", ob[0], 128'h00112233445566778899aabbccddeeff);
    cmp("t1 out_tag", 128'(ot[0]), 128'(5));
    @(posedge clk);
    #1;

    // AddRoundKey to zero, InvMixColumns(0)=0
    send(CT, K2, 4'd1);
    repeat (3) @(negedge clk);
    cmp("t2 out_valid", 128'(ov[1]), 128'(1));
    cmp("t2 out_block", ob[1], '0);
    @(posedge clk);
    #1;

    // uniform columns survive InvMixColumns
    sb_ones = 1;
    send({$urandom, $urandom, $urandom, $urandom}, '0, 4'd3);
    repeat (3) @(negedge clk);
    cmp("t3 out_block", ob[1], {16{8'h01}});
    @(posedge clk);
    #1;
    sb_ones = 0;
    repeat (2) @(posedge clk);
    #1;

    // streaming with a 5-cycle downstream stall
    p2_en = 0;
    pulse_clr();
    rec = 1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, 4'(i));
      end
      begin
        int h;
        h = 0;
        do begin
          @(posedge clk);
          #1;
          h++;
        end while (!ov[1] && h < 50);
        out_ready = 0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    g = 0;
    while (q[1].size() != 0 && g < 60) begin
      @(posedge clk);
      g++;
    end
    @(negedge clk);
    rec = 0;
    cmp("t4 drained", 128'(q[1].size()), 128'(0));
    cmp("t4 tag count", 128'(tags.size()), 128'(8));
    for (int i = 0; i < tags.size(); i++)
      cmp($sformatf("t4 tag order %0d", i), 128'(tags[i]), 128'(i));
`ifdef AES_DEC_PERF_CNT_EN
    cmp("t6 perf_blocks", 128'(pb[1]), 128'(8));
    cmp("t6 perf_stalls", 128'(pst[1]), 128'(5));
    @(posedge clk);
    #1;
    pulse_clr();
    @(negedge clk);
    cmp("t6 clr blocks", 128'(pb[1]), 128'(0));
    cmp("t6 clr stalls", 128'(pst[1]), 128'(0));
`endif
    @(posedge clk);
    #1;

    // reset with three blocks in flight
    out_ready = 0;
    for (int i = 0; i < 3; i++)
      send({$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 4'(8 + i));
    reset_n = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    @(negedge clk);
    cmp("t5 out_valid", 128'(ov[1]), 128'(0));
    cmp("t5 in_ready", 128'(ir[1]), 128'(1));
    cmp("t5 out_block", ob[1], '0);
    cmp("t5 sbox_out", sbo[1], '0);
    @(posedge clk);
    #1;
    out_ready = 1;
    repeat (8) @(posedge clk);
    #1;

    // random traffic on all three instances
    p2_en = 1;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_block  = {$urandom, $urandom, $urandom, $urandom};
      in_key    = {$urandom, $urandom, $urandom, $urandom};
      in_tag    = 4'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 0;
    out_ready = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      cmp($sformatf("final u%0d drained", i), 128'(q[i].size()),
          128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
